// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - Ascon shared state type, permutation FSM encoding and round helpers
package ascon_pkg;

  typedef logic [4:0][63:0] t_state_array;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } t_perm_fsm;

  localparam int MAX_ROUNDS = 12;

  function automatic logic [63:0] round_const(input logic [3:0] i);
    return {56'h0, 4'hF - i, i};
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (32'd64 - n));
  endfunction

  // Unsupported round counts fall back to the full p^a.
  function automatic logic [3:0] decode_rounds(input logic [3:0] r);
    case (r)
      4'd6, 4'd8, 4'd12: return r;
      default:           return 4'(MAX_ROUNDS);
    endcase
  endfunction

endpackage

// File: rtl/ascon_permutation_iter_if.sv
// rtl/ascon_permutation_iter_if.sv - state in/out handshake bundle; i_abort exists only with ASCON_PERM_ABORT_EN
interface ascon_permutation_iter_if;
  import ascon_pkg::*;

  t_state_array i_state;
  logic [3:0]   i_rounds;
  logic         i_valid;
  logic         o_ready;
  t_state_array o_state;
  logic         o_valid;
  logic         i_ready;

`ifdef ASCON_PERM_ABORT_EN
  logic         i_abort;

  modport slave (
    input  i_state, i_rounds, i_valid, i_ready, i_abort,
    output o_ready, o_state, o_valid
  );
  modport master (
    output i_state, i_rounds, i_valid, i_ready, i_abort,
    input  o_ready, o_state, o_valid
  );
`else
  modport slave (
    input  i_state, i_rounds, i_valid, i_ready,
    output o_ready, o_state, o_valid
  );
  modport master (
    output i_state, i_rounds, i_valid, i_ready,
    input  o_ready, o_state, o_valid
  );
`endif

endinterface

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational Ascon round: constant add, bit-sliced S-box, linear diffusion
module ascon_round
  import ascon_pkg::*;
(
  input  t_state_array state_i,
  input  logic [3:0]   rnd_i,
  output t_state_array state_o
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  always_comb begin
    x0 = state_i[0];
    x1 = state_i[1];
    x2 = state_i[2] ^ round_const(rnd_i);
    x3 = state_i[3];
    x4 = state_i[4];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    state_o[0] = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    state_o[1] = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    state_o[2] = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    state_o[3] = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    state_o[4] = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
  end

endmodule

// File: rtl/ascon_permutation_iter.sv
// rtl/ascon_permutation_iter.sv - iterative Ascon p^a/p^b, ROUNDS_PER_CYCLE rounds per clock
// Optional abort input enabled by ASCON_PERM_ABORT_EN.
module ascon_permutation_iter
  import ascon_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input logic                     i_clk,
  input logic                     i_rst,
  ascon_permutation_iter_if.slave bus
);

  t_perm_fsm    fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  t_state_array state_q, state_d;
  t_state_array chain [ROUNDS_PER_CYCLE+1];

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) begin : g_rpc_check
    $error("ascon_permutation_iter: ROUNDS_PER_CYCLE must be 1 or 2");
  end

  // Rounds chained within one cycle consume consecutive round indices.
  assign chain[0] = state_q;
  for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
    ascon_round u_round (
      .state_i (chain[k]),
      .rnd_i   (rnd_q + 4'(k)),
      .state_o (chain[k+1])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fsm_q   <= IDLE;
      rnd_q   <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    case (fsm_q)
      IDLE: begin
        if (bus.i_valid) begin
          state_d = bus.i_state;
          rnd_d   = 4'(MAX_ROUNDS) - decode_rounds(bus.i_rounds);
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = chain[ROUNDS_PER_CYCLE];
        rnd_d   = rnd_q + 4'(ROUNDS_PER_CYCLE);
        if (rnd_d == 4'(MAX_ROUNDS)) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          fsm_d = IDLE;
          rnd_d = '0;
        end
      end
      default: begin
        fsm_d = IDLE;
        rnd_d = '0;
      end
    endcase
`ifdef ASCON_PERM_ABORT_EN
    // Abort wins over i_ready and leaves the working register untouched.
    if (bus.i_abort && fsm_q != IDLE) begin
      fsm_d   = IDLE;
      rnd_d   = '0;
      state_d = state_q;
    end
`endif
  end

  assign bus.o_ready = (fsm_q == IDLE) && !i_rst;
  assign bus.o_valid = (fsm_q == DONE);
  assign bus.o_state = state_q;

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// tb/tb_ascon_permutation_iter.sv - self-checking bench: table vectors plus handshake corner sequences
module tb_ascon_permutation_iter;
  import ascon_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ascon_permutation_iter_if if1 ();
  ascon_permutation_iter_if if2 ();

  ascon_permutation_iter #(.ROUNDS_PER_CYCLE(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));
  ascon_permutation_iter #(.ROUNDS_PER_CYCLE(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(if2));

  typedef struct {
    int           sel;
    t_state_array st;
    logic [3:0]   rounds;
    int           lat;
    t_state_array exp;
  } vec_t;

  vec_t vecs [8];

  // Reference: column-wise 5-bit S-box lookup with x0 as the MSB.
  function automatic logic [4:0] sbox(input int v);
    logic [4:0] t [32];
    t = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
          5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
          5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
          5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    return t[v];
  endfunction

  function automatic logic [63:0] rot(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic int nrounds(input logic [3:0] r);
    return (r == 4'd6 || r == 4'd8 || r == 4'd12) ? int'(r) : 12;
  endfunction

  function automatic t_state_array model_perm(input t_state_array s, input logic [3:0] r_in);
    int         nr;
    int         v;
    logic [4:0] o;
    nr = nrounds(r_in);
    for (int r = 12 - nr; r < 12; r++) begin
      s[2] = s[2] ^ 64'((15 - r) * 16 + r);
      for (int c = 0; c < 64; c++) begin
        v = int'({s[0][c], s[1][c], s[2][c], s[3][c], s[4][c]});
        o = sbox(v);
        s[0][c] = o[4];
        s[1][c] = o[3];
        s[2][c] = o[2];
        s[3][c] = o[1];
        s[4][c] = o[0];
      end
      s[0] = s[0] ^ rot(s[0], 19) ^ rot(s[0], 28);
      s[1] = s[1] ^ rot(s[1], 61) ^ rot(s[1], 39);
      s[2] = s[2] ^ rot(s[2], 1)  ^ rot(s[2], 6);
      s[3] = s[3] ^ rot(s[3], 10) ^ rot(s[3], 17);
      s[4] = s[4] ^ rot(s[4], 7)  ^ rot(s[4], 41);
    end
    return s;
  endfunction

  function automatic t_state_array rand_state();
    t_state_array s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
    return s;
  endfunction

  function automatic logic get_valid(input int sel);
    return (sel == 1) ? if1.o_valid : if2.o_valid;
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel == 1) ? if1.o_ready : if2.o_ready;
  endfunction

  function automatic t_state_array get_state(input int sel);
    return (sel == 1) ? if1.o_state : if2.o_state;
  endfunction

  task automatic check(input string nm, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive_in(input int sel, input logic v, input t_state_array s, input logic [3:0] r);
    if (sel == 1) begin
      if1.i_valid = v; if1.i_state = s; if1.i_rounds = r;
    end else begin
      if2.i_valid = v; if2.i_state = s; if2.i_rounds = r;
    end
  endtask

  task automatic set_ready(input int sel, input logic rdy);
    if (sel == 1) if1.i_ready = rdy;
    else          if2.i_ready = rdy;
  endtask

  // Called at a negedge; returns #1 after the accepting posedge with i_valid dropped.
  task automatic accept(input int sel, input t_state_array s, input logic [3:0] r, input string nm);
    drive_in(sel, 1'b1, s, r);
    #1;
    check({nm, "_rdy"}, 320'(get_ready(sel)), 320'(1'b1));
    @(posedge clk);
    #1;
    drive_in(sel, 1'b0, s, r);
  endtask

  task automatic wait_valid(input int sel, input int bound, output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (get_valid(sel)) break;
      lat++;
      if (lat > bound) break;
    end
  endtask

  task automatic do_perm(input int sel, input t_state_array s, input logic [3:0] r,
                         input int lat_exp, input t_state_array exp, input string nm);
    int lat;
    accept(sel, s, r, nm);
    wait_valid(sel, 40, lat);
    check({nm, "_lat"}, 320'(lat), 320'(lat_exp));
    check({nm, "_state"}, get_state(sel), exp);
    set_ready(sel, 1'b1);
    @(negedge clk);
    set_ready(sel, 1'b0);
    check({nm, "_idle"}, 320'({get_valid(sel), get_ready(sel)}), 320'(2'b01));
  endtask

  task automatic check_quiet(input int sel, input int n, input string nm);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (get_valid(sel)) seen = 1'b1;
    end
    check(nm, 320'(seen), 320'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    t_state_array iv, s1, s2;
    int           lat;

    iv    = '0;
    iv[0] = 64'h80400c0600000000;
    vecs[0] = '{sel: 1, st: iv,           rounds: 4'd12, lat: 0, exp: '0};
    vecs[1] = '{sel: 2, st: rand_state(), rounds: 4'd6,  lat: 0, exp: '0};
    vecs[2] = '{sel: 2, st: rand_state(), rounds: 4'd8,  lat: 0, exp: '0};
    vecs[3] = '{sel: 1, st: rand_state(), rounds: 4'd8,  lat: 0, exp: '0};
    vecs[4] = '{sel: 1, st: rand_state(), rounds: 4'd6,  lat: 0, exp: '0};
    vecs[5] = '{sel: 2, st: rand_state(), rounds: 4'd12, lat: 0, exp: '0};
    vecs[6] = '{sel: 2, st: rand_state(), rounds: 4'd5,  lat: 0, exp: '0};
    vecs[7] = '{sel: 1, st: rand_state(), rounds: 4'd15, lat: 0, exp: '0};
    for (int i = 0; i < 8; i++) begin
      vecs[i].lat = nrounds(vecs[i].rounds) / vecs[i].sel;
      vecs[i].exp = model_perm(vecs[i].st, vecs[i].rounds);
    end

`ifdef ASCON_PERM_ABORT_EN
    if1.i_abort = 1'b0;
    if2.i_abort = 1'b0;
`endif
    set_ready(1, 1'b0);
    set_ready(2, 1'b0);

    // Reset held with i_valid asserted on both instances.
    rst = 1'b1;
    drive_in(1, 1'b1, iv, 4'd12);
    drive_in(2, 1'b1, iv, 4'd12);
    repeat (2) begin
      @(negedge clk);
      for (int d = 1; d <= 2; d++) begin
        check($sformatf("rst_valid%0d", d), 320'(get_valid(d)), 320'(1'b0));
        check($sformatf("rst_ready%0d", d), 320'(get_ready(d)), 320'(1'b0));
        check($sformatf("rst_state%0d", d), get_state(d), 320'(0));
      end
    end
    drive_in(1, 1'b0, iv, 4'd12);
    drive_in(2, 1'b0, iv, 4'd12);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 1; d <= 2; d++) begin
      check($sformatf("post_rst_rdy%0d", d), 320'({get_valid(d), get_ready(d)}), 320'(2'b01));
      check($sformatf("post_rst_state%0d", d), get_state(d), 320'(0));
    end

    for (int i = 0; i < 8; i++) begin
      do_perm(vecs[i].sel, vecs[i].st, vecs[i].rounds, vecs[i].lat, vecs[i].exp,
              $sformatf("vec%0d", i));
    end

    // Backpressure: result held while i_ready stays low, new input waits.
    s1 = rand_state();
    s2 = rand_state();
    accept(1, s1, 4'd6, "bp");
    wait_valid(1, 40, lat);
    check("bp_lat", 320'(lat), 320'(6));
    drive_in(1, 1'b1, s2, 4'd8);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", c),
            {get_state(1)} ^ 320'({get_valid(1), get_ready(1)}),
            model_perm(s1, 4'd6) ^ 320'(2'b10));
    end
    set_ready(1, 1'b1);
    @(posedge clk);
    #1;
    set_ready(1, 1'b0);
    @(negedge clk);
    check("bp_idle", 320'({get_valid(1), get_ready(1)}), 320'(2'b01));
    @(posedge clk);
    #1;
    drive_in(1, 1'b0, s2, 4'd8);
    wait_valid(1, 40, lat);
    check("bp_next_lat", 320'(lat), 320'(8));
    check("bp_next_state", get_state(1), model_perm(s2, 4'd8));
    set_ready(1, 1'b1);
    @(negedge clk);
    set_ready(1, 1'b0);

    // Reset in the middle of a run.
    accept(1, rand_state(), 4'd12, "mrst");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_during", 320'({get_valid(1), get_ready(1)}), 320'(2'b00));
    rst = 1'b0;
    #1;
    check("mrst_rdy", 320'({get_valid(1), get_ready(1)}), 320'(2'b01));
    check_quiet(1, 15, "mrst_quiet");
    s1 = rand_state();
    do_perm(1, s1, 4'd12, 12, model_perm(s1, 4'd12), "mrst_after");

`ifdef ASCON_PERM_ABORT_EN
    accept(1, rand_state(), 4'd12, "ab_run");
    repeat (3) @(negedge clk);
    if1.i_abort = 1'b1;
    @(negedge clk);
    if1.i_abort = 1'b0;
    check("ab_run_idle", 320'({get_valid(1), get_ready(1)}), 320'(2'b01));
    check_quiet(1, 14, "ab_run_quiet");

    accept(1, rand_state(), 4'd8, "ab_done");
    wait_valid(1, 40, lat);
    check("ab_done_lat", 320'(lat), 320'(8));
    if1.i_abort = 1'b1;
    set_ready(1, 1'b1);
    @(negedge clk);
    if1.i_abort = 1'b0;
    set_ready(1, 1'b0);
    check("ab_done_idle", 320'({get_valid(1), get_ready(1)}), 320'(2'b01));

    s1 = rand_state();
    if1.i_abort = 1'b1;
    accept(1, s1, 4'd6, "ab_idle");
    if1.i_abort = 1'b0;
    wait_valid(1, 40, lat);
    check("ab_idle_lat", 320'(lat), 320'(6));
    check("ab_idle_state", get_state(1), model_perm(s1, 4'd6));
    set_ready(1, 1'b1);
    @(negedge clk);
    set_ready(1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
